// File: rtl/module_pipe_flops.sv
// module_pipe_flops: DEPTH-stage valid/ready register pipeline with bubble collapse,
// synchronous flush and an occupancy count.
// Optional build macro: MODULE_PIPE_FLOPS_ZERO_INVALID_EN forces data_out_pipe to zero
// whenever valid_out_pipe is low; without it the last stage data is always visible.
module module_pipe_flops #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_pipe_flops,
    input  logic                       reset_L,
    input  logic                       valid_in_pipe,
    input  logic [WIDTH-1:0]           data_in_pipe,
    output logic                       ready_in_pipe,
    output logic                       valid_out_pipe,
    output logic [WIDTH-1:0]           data_out_pipe,
    input  logic                       ready_out_pipe,
    input  logic                       flush_pipe,
    output logic [$clog2(DEPTH+1)-1:0] count_pipe
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [DEPTH-1:0] move;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             in_fire;
    logic             carry;

    // Per-stage advance enables, rippling back from the output stage.
    always_comb begin
        move  = '0;
        carry = !v_q[DEPTH-1] || ready_out_pipe;
        move[DEPTH-1] = carry;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            carry   = !v_q[k] || carry;
            move[k] = carry;
        end
    end

    // Handshake outputs; reset blanks them combinationally.
    always_comb begin
        ready_in_pipe  = move[0] && !flush_pipe && reset_L;
        valid_out_pipe = v_q[DEPTH-1] && reset_L;
        in_fire        = valid_in_pipe && ready_in_pipe;
    end

    // Output data, optionally zeroed when no valid word is presented.
    always_comb begin
`ifdef MODULE_PIPE_FLOPS_ZERO_INVALID_EN
        data_out_pipe = valid_out_pipe ? d_q[DEPTH-1] : '0;
`else
        data_out_pipe = d_q[DEPTH-1];
`endif
    end

    // Next-state for stage valids and data; flush clears valids but keeps data.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_pipe) begin
            v_d = '0;
        end else begin
            if (move[0]) begin
                v_d[0] = in_fire;
                if (in_fire) begin
                    d_d[0] = data_in_pipe;
                end
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (move[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end
    end

    // Occupancy is recomputed from the next valid vector so it never drifts.
    always_comb begin
        count_d = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            count_d = count_d + CW'(v_d[k]);
        end
    end

    // State registers with synchronous active-low reset taking top priority.
    always_ff @(posedge clk_pipe_flops) begin
        if (!reset_L) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q     <= v_d;
            count_q <= count_d;
            for (int k = 0; k < int'(DEPTH); k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    assign count_pipe = count_q;

endmodule

// File: tb/tb_module_pipe_flops.sv
// Self-checking bench for module_pipe_flops: directed scenarios plus random traffic,
// compared against a word-list model where each held word carries its stage position.
module tb_module_pipe_flops;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rl, fl, vi, ro;
    logic [WIDTH-1:0] di;
    logic             ready_in, valid_out;
    logic [WIDTH-1:0] data_out;
    logic [2:0]       count;

    module_pipe_flops #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_pipe_flops (clk),
        .reset_L        (rl),
        .valid_in_pipe  (vi),
        .data_in_pipe   (di),
        .ready_in_pipe  (ready_in),
        .valid_out_pipe (valid_out),
        .data_out_pipe  (data_out),
        .ready_out_pipe (ro),
        .flush_pipe     (fl),
        .count_pipe     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: held words oldest first, with their stage index.
    logic [31:0] mq[$];
    int          mp[$];
    logic [31:0] last_d;
    logic [31:0] sb[$];

    logic        obs_ready, obs_valid;
    logic [31:0] obs_data, obs_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // True when no held word would sit in stage 0 after this edge's movement.
    function automatic bit stage0_free(input bit o);
        int limit = DEPTH;
        int np;
        bit free = 1'b1;
        foreach (mp[i]) begin
            if (i == 0 && mp[i] == DEPTH - 1 && o) continue;
            np = (mp[i] + 1 < limit) ? mp[i] + 1 : mp[i];
            limit = np;
            if (np == 0) free = 1'b0;
        end
        return free;
    endfunction

    function automatic void model_edge(input bit r, input bit f, input bit acc,
                                       input logic [31:0] dd, input bit o);
        int limit;
        int np;
        int nmp[$];
        logic [31:0] nmq[$];
        if (!r) begin
            mq.delete();
            mp.delete();
            last_d = '0;
            return;
        end
        if (f) begin
            mq.delete();
            mp.delete();
            return;
        end
        limit = DEPTH;
        foreach (mp[i]) begin
            if (i == 0 && mp[i] == DEPTH - 1 && o) continue;
            np = (mp[i] + 1 < limit) ? mp[i] + 1 : mp[i];
            if (np == DEPTH - 1 && mp[i] != DEPTH - 1) last_d = mq[i];
            limit = np;
            nmp.push_back(np);
            nmq.push_back(mq[i]);
        end
        if (acc) begin
            nmp.push_back(0);
            nmq.push_back(dd);
            if (DEPTH == 1) last_d = dd;
        end
        mp = nmp;
        mq = nmq;
    endfunction

    // One cycle: drive at negedge, check combinational/registered outputs, clock, update model.
    task automatic step(input bit r, input bit f, input bit v, input logic [31:0] dd,
                        input bit o);
        bit          e_ready, e_valid;
        logic [31:0] e_data;
        rl = r; fl = f; vi = v; di = dd; ro = o;
        #1;
        e_ready = r && !f && stage0_free(o);
        e_valid = r && (mp.size() > 0) && (mp[0] == DEPTH - 1);
        if (e_valid) e_data = mq[0];
        else begin
`ifdef MODULE_PIPE_FLOPS_ZERO_INVALID_EN
            e_data = '0;
`else
            e_data = last_d;
`endif
        end
        obs_ready = ready_in;
        obs_valid = valid_out;
        obs_data  = data_out;
        obs_count = 32'(count);
        check("ready_in", obs_ready, e_ready);
        check("valid_out", obs_valid, e_valid);
        check("data_out", obs_data, e_data);
        check("count", obs_count, mq.size());
        if (r && !f && obs_valid && o) begin
            if (sb.size() == 0) check("emit_unexpected", 1, 0);
            else check("emit_order", obs_data, sb.pop_front());
        end
        if (v && e_ready) sb.push_back(dd);
        @(posedge clk);
        model_edge(r, f, v && e_ready, dd, o);
        if (!r || f) sb.delete();
        @(negedge clk);
    endtask

    initial begin
        int w;
        clk = 0; rl = 0; fl = 0; vi = 0; ro = 0; di = '0;
        last_d = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state.
        step(0, 0, 0, 0, 1);

        // Streaming at full rate: latency DEPTH, count steady.
        for (int c = 0; c < 12; c++) begin
            step(1, 0, c < 8, 32'hA0 + c, 1);
            if (c >= 4) begin
                check("stream_valid", obs_valid, 1);
                check("stream_data", obs_data, 32'hA0 + c - 4);
            end
            if (c >= 4 && c <= 8) check("stream_count", obs_count, 4);
        end

        // Stalled fill then drain.
        step(0, 0, 0, 0, 0);
        w = 0;
        for (int c = 0; c < 6; c++) begin
            step(1, 0, 1, 32'hB0 + w, 0);
            if (obs_ready) w++;
            if (c >= 4) begin
                check("full_ready", obs_ready, 0);
                check("full_count", obs_count, 4);
            end
        end
        check("fill_accepted", w, 4);
        for (int c = 0; c < 20; c++) begin
            step(1, 0, w < 6, 32'hB0 + w, 1);
            if (obs_ready && w < 6) w++;
        end
        check("drain_accepted", w, 6);

        // Full pipe with simultaneous in and out.
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) step(1, 0, 1, 32'hC0 + c, 0);
        step(1, 0, 1, 32'hC4, 1);
        check("pass_ready", obs_ready, 1);
        check("pass_data", obs_data, 32'hC0);
        step(1, 0, 0, 0, 0);
        check("pass_count", obs_count, 4);

        // Flush with three words held.
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) step(1, 0, 1, 32'hD0 + c, 0);
        step(1, 1, 1, 32'hDF, 1);
        for (int c = 0; c < 4; c++) begin
            step(1, 0, 0, 0, 1);
            check("flush_valid", obs_valid, 0);
            check("flush_count", obs_count, 0);
        end

        // Reset mid-stream with two words held.
        step(0, 0, 0, 0, 0);
        for (int c = 0; c < 2; c++) step(1, 0, 1, 32'hE0 + c, 0);
        step(0, 0, 1, 32'hEE, 1);
        check("rst_valid", obs_valid, 0);
        check("rst_ready", obs_ready, 0);
        step(1, 0, 1, 32'hE5, 1);
        check("rst_count", obs_count, 0);
        check("rst_data", obs_data, 0);
        check("rst_accept", obs_ready, 1);

        // Last word drained: data_out after it leaves.
        step(0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h55, 1);
        for (int c = 0; c < 5; c++) step(1, 0, 0, 0, 1);
`ifdef MODULE_PIPE_FLOPS_ZERO_INVALID_EN
        check("drained_data", obs_data, 0);
`else
        check("drained_data", obs_data, 32'h55);
`endif
        check("drained_valid", obs_valid, 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_pipe_flops.md
MODULE_PIPE_FLOPS -- requirements
Module: module_pipe_flops

Interface
REQ-001 Parameter: WIDTH, 32, data word width in bits (>=1).
REQ-002 Parameter: DEPTH, 4, number of register stages (>=1).
REQ-003 Port: clk_pipe_flops  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset_L  input  1  reset, synchronous, active-low.
REQ-005 Port: valid_in_pipe  input  1  upstream word valid.
REQ-006 Port: data_in_pipe  input  WIDTH  upstream word.
REQ-007 Port: ready_in_pipe  output  1  block accepts a word this cycle (combinational).
REQ-008 Port: valid_out_pipe  output  1  downstream word valid.
REQ-009 Port: data_out_pipe  output  WIDTH  downstream word.
REQ-010 Port: ready_out_pipe  input  1  downstream accepts a word this cycle.
REQ-011 Port: flush_pipe  input  1  synchronous discard of all held words.
REQ-012 Port: count_pipe  output  $clog2(DEPTH+1)  number of occupied stages, registered.

Function
REQ-013 State SHALL be DEPTH stages k=0..DEPTH-1, each a valid bit v[k] and a data register d[k]; stage 0 is the input, stage DEPTH-1 drives the outputs.
REQ-014 move[DEPTH-1] SHALL be !v[DEPTH-1] || ready_out_pipe; move[k] (k<DEPTH-1) SHALL be !v[k] || move[k+1].
REQ-015 ready_in_pipe SHALL equal move[0] && !flush_pipe && reset_L.
REQ-016 A transfer in SHALL occur on an edge with valid_in_pipe && ready_in_pipe; a transfer out on an edge with valid_out_pipe && ready_out_pipe.
REQ-017 On an edge with move[k]: v[k] SHALL load the upstream valid (valid_in_pipe && ready_in_pipe for k=0, v[k-1] otherwise); d[k] SHALL load upstream data only when that upstream valid is 1, else hold.
REQ-018 Without move[k], v[k] and d[k] SHALL hold.
REQ-019 valid_out_pipe SHALL equal v[DEPTH-1] while reset_L=1, and 0 combinationally while reset_L=0.
REQ-020 With ready_out_pipe held 1, a word accepted in cycle n SHALL appear on valid_out_pipe/data_out_pipe in cycle n+DEPTH.
REQ-021 Bubbles SHALL collapse under stall: an empty stage ahead of a stalled valid stage SHALL still accept.
REQ-022 Full (all v=1, ready_out_pipe=0) SHALL drive ready_in_pipe=0; full with ready_out_pipe=1 SHALL accept and emit in the same cycle.
REQ-023 Words SHALL never be lost, duplicated or reordered.
REQ-024 flush_pipe=1 SHALL clear every v[k] at the edge, take priority over input and output movement, and hold every d[k]; count_pipe SHALL be 0 the following cycle.
REQ-025 count_pipe SHALL equal the number of set v[k] after each edge; simultaneous transfer in and out SHALL leave it unchanged.

Reset
REQ-026 On an edge with reset_L=0: all v[k]=0, all d[k]=0, count_pipe=0; reset takes priority over flush_pipe and all transfers.
REQ-027 While reset_L=0: valid_out_pipe=0, ready_in_pipe=0, data_out_pipe=0 after the first reset edge.
REQ-028 Reset asserted mid-stream SHALL discard all held words; the first edge with reset_L=1 SHALL be able to accept a word.

Configuration
REQ-029 Macro MODULE_PIPE_FLOPS_ZERO_INVALID_EN defined: data_out_pipe SHALL be forced to 0 whenever valid_out_pipe=0.
REQ-030 Macro undefined: data_out_pipe SHALL always equal d[DEPTH-1], holding the last valid word after it leaves.

Verification
REQ-031 DEPTH=4, ready_out=1, valid_in words 0xA0..0xA7 cycles 0-7 -> outputs 0xA0..0xA7 valid cycles 4-11, count_pipe steady at 4.
REQ-032 DEPTH=4, ready_out=0, 6 words offered -> 4 accepted, ready_in=0 thereafter, count_pipe=4; ready_out=1 -> 4 words out in order, remaining 2 accepted.
REQ-033 Full pipe, ready_out=1 and valid_in=1 same cycle -> one word out, one in, count_pipe stays 4.
REQ-034 Pipe holding 3 words, flush_pipe=1 one cycle -> valid_out=0, count_pipe=0 next cycle, no flushed word ever emitted.
REQ-035 reset_L=0 with 2 words held -> valid_out=0 immediately, count_pipe=0 and data_out=0 after edge; release -> word accepted first cycle.
REQ-036 Last word 0x55 drained, valid_in=0 -> data_out=0 with MODULE_PIPE_FLOPS_ZERO_INVALID_EN defined, 0x55 without.
